// File: rtl/adder_nios_onchip_mem_dp_pkg.sv
// Shared constants and helpers for the dual-port on-chip memory.
// Holds the latency encodings, the address-width helper and the cross-port byte-lane rule.
package adder_nios_mem_pkg;

    localparam int LAT_UNREG = 1;
    localparam int LAT_REG   = 2;

    function automatic int mem_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Byte-lane merge on a same-word double write: s1 owns every lane it enables,
    // s2 keeps only the lanes s1 leaves alone.
    function automatic logic s2_lane_wr(input logic s2_be, input logic s1_be, input logic same_word);
        return s2_be & ~(s1_be & same_word);
    endfunction

endpackage

// File: rtl/adder_nios_onchip_mem_dp_if.sv
// One Avalon-MM pipelined slave port of the on-chip memory (word addressed, byte enables).
// Latency and waitrequest behaviour are owned by the memory; this only bundles the wires.
interface adder_nios_onchip_mem_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/adder_nios_onchip_mem_dp_rd_pipe.sv
// Per-port read response pipeline: valid shift register plus optional output register.
// Latency READ_LATENCY enabled cycles; en=0 freezes every stage and masks the valid pulse.
module adder_nios_mem_rd_pipe
    import adder_nios_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = LAT_UNREG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              rd_acc,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    logic v1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            v1 <= 1'b0;
        else if (en)
            v1 <= rd_acc;
    end

    // A frozen response is only presented in an enabled cycle, so it pulses exactly once.
    generate
        if (READ_LATENCY == LAT_UNREG) begin : g_unreg
            assign readdata      = ram_q;
            assign readdatavalid = v1 & en;
        end else if (READ_LATENCY == LAT_REG) begin : g_reg
            logic              v2;
            logic [DATA_W-1:0] q2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    q2 <= '0;
                end else if (en) begin
                    v2 <= v1;
                    if (v1)
                        q2 <= ram_q;
                end
            end

            assign readdata      = q2;
            assign readdatavalid = v2 & en;
        end else begin : g_bad
            $error("adder_nios_mem_rd_pipe: READ_LATENCY must be 1 or 2");
            assign readdata      = '0;
            assign readdatavalid = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/adder_nios_onchip_mem_dp.sv
// True dual-port byte-enabled on-chip RAM with two Avalon-MM pipelined slaves (s1 CPU, s2 DMA).
// Read latency READ_LATENCY; waitrequest = ~clken | reset_req stalls both ports and freezes responses.
module adder_nios_onchip_mem_dp
    import adder_nios_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8192,
    parameter int ADDR_W       = mem_addr_w(DEPTH),
    parameter int READ_LATENCY = LAT_UNREG
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clken,
    input  logic                        reset_req,
    adder_nios_onchip_mem_dp_if.slave   s1,
    adder_nios_onchip_mem_dp_if.slave   s2
);

    localparam int NB = DATA_W / 8;

    logic              stall;
    logic              en;
    logic              wr1, wr2, rd1, rd2;
    logic              same_word;
    logic [DATA_W-1:0] ram_q1, ram_q2;
    logic [DATA_W-1:0] mem [DEPTH];

    assign stall          = ~clken | reset_req;
    assign en             = ~stall;
    assign s1.waitrequest = stall;
    assign s2.waitrequest = stall;

    // Write wins over read when a port asserts both.
    assign wr1       = en & s1.chipselect & s1.write;
    assign wr2       = en & s2.chipselect & s2.write;
    assign rd1       = en & s1.chipselect & s1.read & ~s1.write;
    assign rd2       = en & s2.chipselect & s2.read & ~s2.write;
    assign same_word = wr1 & wr2 & (s1.address == s2.address);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr1 && s1.byteenable[i])
                mem[s1.address][8*i +: 8] <= s1.writedata[8*i +: 8];
            if (wr2 && s2_lane_wr(s2.byteenable[i], s1.byteenable[i], same_word))
                mem[s2.address][8*i +: 8] <= s2.writedata[8*i +: 8];
        end
    end

    // Sampled at the accepting edge, so a same-edge write is not yet visible (read-before-write).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_q1 <= '0;
            ram_q2 <= '0;
        end else begin
            if (rd1)
                ram_q1 <= mem[s1.address];
            if (rd2)
                ram_q2 <= mem[s2.address];
        end
    end

    adder_nios_mem_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_s1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .rd_acc        (rd1),
        .ram_q         (ram_q1),
        .readdata      (s1.readdata),
        .readdatavalid (s1.readdatavalid)
    );

    adder_nios_mem_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_s2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .rd_acc        (rd2),
        .ram_q         (ram_q2),
        .readdata      (s2.readdata),
        .readdatavalid (s2.readdatavalid)
    );

endmodule

// File: tb/tb_adder_nios_onchip_mem_dp.sv
// Directed bench for the dual-port on-chip memory: one latency-1 and one latency-2 instance.
// Inputs change at the falling edge; outputs are checked just after, as the next rising edge will see them.
module tb_adder_nios_onchip_mem_dp;
    import adder_nios_mem_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    logic reset_req;
    int   errs   = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    adder_nios_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(13)) a1 ();
    adder_nios_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(13)) a2 ();
    adder_nios_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(13)) b1 ();
    adder_nios_onchip_mem_dp_if #(.DATA_W(32), .ADDR_W(13)) b2 ();

    adder_nios_onchip_mem_dp #(
        .DATA_W(32), .DEPTH(8192), .ADDR_W(13), .READ_LATENCY(LAT_UNREG)
    ) u_lat1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(a1), .s2(a2)
    );

    adder_nios_onchip_mem_dp #(
        .DATA_W(32), .DEPTH(8192), .ADDR_W(13), .READ_LATENCY(LAT_REG)
    ) u_lat2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(b1), .s2(b2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_a1(input logic cs, input logic rd, input logic wr, input logic [12:0] ad,
                          input logic [31:0] d, input logic [3:0] be);
        a1.chipselect = cs; a1.read = rd; a1.write = wr;
        a1.address = ad; a1.writedata = d; a1.byteenable = be;
    endtask

    task automatic set_a2(input logic cs, input logic rd, input logic wr, input logic [12:0] ad,
                          input logic [31:0] d, input logic [3:0] be);
        a2.chipselect = cs; a2.read = rd; a2.write = wr;
        a2.address = ad; a2.writedata = d; a2.byteenable = be;
    endtask

    task automatic set_b1(input logic cs, input logic rd, input logic wr, input logic [12:0] ad,
                          input logic [31:0] d, input logic [3:0] be);
        b1.chipselect = cs; b1.read = rd; b1.write = wr;
        b1.address = ad; b1.writedata = d; b1.byteenable = be;
    endtask

    task automatic set_b2(input logic cs, input logic rd, input logic wr, input logic [12:0] ad,
                          input logic [31:0] d, input logic [3:0] be);
        b2.chipselect = cs; b2.read = rd; b2.write = wr;
        b2.address = ad; b2.writedata = d; b2.byteenable = be;
    endtask

    task automatic idle();
        set_a1(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        set_a2(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        set_b1(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        set_b2(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
    endtask

    initial begin
        reset_n   = 1'b1;
        clken     = 1'b1;
        reset_req = 1'b0;
        idle();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_b("rst_a1_vld", a1.readdatavalid, 1'b0);
        chk  ("rst_a1_dat", a1.readdata, 32'h0);
        chk_b("rst_a2_vld", a2.readdatavalid, 1'b0);
        chk  ("rst_a2_dat", a2.readdata, 32'h0);
        chk_b("rst_b1_vld", b1.readdatavalid, 1'b0);
        chk  ("rst_b1_dat", b1.readdata, 32'h0);

        @(negedge clk) reset_n = 1'b1;
        #1 chk_b("wait_idle", a1.waitrequest, 1'b0);
        clken = 1'b0;
        #1 chk_b("wait_clken_s1", a1.waitrequest, 1'b1);
        chk_b("wait_clken_s2", a2.waitrequest, 1'b1);
        clken = 1'b1; reset_req = 1'b1;
        #1 chk_b("wait_rstreq", a1.waitrequest, 1'b1);
        reset_req = 1'b0;

        // Preload 0x5 through s2, read it back through s1.
        @(negedge clk) set_a2(1'b1, 1'b0, 1'b1, 13'h005, 32'hDEADBEEF, 4'hF);
        @(negedge clk) idle(); set_a1(1'b1, 1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        #1 chk_b("wr_no_vld", a2.readdatavalid, 1'b0);
        @(negedge clk) idle();
        #1 chk_b("rd5_vld", a1.readdatavalid, 1'b1);
        chk("rd5_dat", a1.readdata, 32'hDEADBEEF);
        @(negedge clk);
        #1 chk_b("rd5_pulse_end", a1.readdatavalid, 1'b0);
        chk("rd5_hold", a1.readdata, 32'hDEADBEEF);

        // Partial byte write, then read on the very next edge.
        @(negedge clk) set_a2(1'b1, 1'b0, 1'b1, 13'h010, 32'hAAAAAAAA, 4'hF);
        set_a1(1'b1, 1'b0, 1'b1, 13'h020, 32'h0, 4'hF);
        @(negedge clk) idle(); set_a2(1'b1, 1'b0, 1'b1, 13'h010, 32'h11223344, 4'b0101);
        @(negedge clk) idle(); set_a1(1'b1, 1'b1, 1'b0, 13'h010, 32'h0, 4'h0);
        @(negedge clk) idle();
        #1 chk_b("be_vld", a1.readdatavalid, 1'b1);
        chk("be_dat", a1.readdata, 32'hAA22AA44);

        // Same-edge double write to one word.
        @(negedge clk) set_a1(1'b1, 1'b0, 1'b1, 13'h020, 32'h000000FF, 4'b0001);
        set_a2(1'b1, 1'b0, 1'b1, 13'h020, 32'h0000EE00, 4'b0011);
        @(negedge clk) idle(); set_a1(1'b1, 1'b1, 1'b0, 13'h020, 32'h0, 4'h0);
        @(negedge clk) idle();
        #1 chk_b("ww_vld", a1.readdatavalid, 1'b1);
        chk("ww_dat", a1.readdata, 32'h0000EEFF);

        // Same-edge s1 write / s2 read returns the old word, then the new one.
        @(negedge clk) set_a1(1'b1, 1'b0, 1'b1, 13'h030, 32'h7, 4'hF);
        @(negedge clk) idle(); set_a1(1'b1, 1'b0, 1'b1, 13'h030, 32'h5, 4'hF);
        set_a2(1'b1, 1'b1, 1'b0, 13'h030, 32'h0, 4'h0);
        @(negedge clk) idle(); set_a2(1'b1, 1'b1, 1'b0, 13'h030, 32'h0, 4'h0);
        #1 chk_b("rbw_old_vld", a2.readdatavalid, 1'b1);
        chk("rbw_old_dat", a2.readdata, 32'h7);
        @(negedge clk) idle();
        #1 chk_b("rbw_new_vld", a2.readdatavalid, 1'b1);
        chk("rbw_new_dat", a2.readdata, 32'h5);

        // read and write together on one port: write only.
        @(negedge clk) set_a2(1'b1, 1'b1, 1'b1, 13'h040, 32'h99, 4'hF);
        @(negedge clk) idle(); set_a2(1'b1, 1'b1, 1'b0, 13'h040, 32'h0, 4'h0);
        #1 chk_b("rw_no_vld", a2.readdatavalid, 1'b0);
        @(negedge clk) idle();
        #1 chk_b("rw_rd_vld", a2.readdatavalid, 1'b1);
        chk("rw_rd_dat", a2.readdata, 32'h99);

        // Four back-to-back reads with a three-cycle clken stall after the second accept.
        @(negedge clk) set_a1(1'b1, 1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        @(negedge clk) set_a1(1'b1, 1'b1, 1'b0, 13'h010, 32'h0, 4'h0);
        #1 chk_b("b2b0_vld", a1.readdatavalid, 1'b1);
        chk("b2b0_dat", a1.readdata, 32'hDEADBEEF);
        @(negedge clk) set_a1(1'b1, 1'b1, 1'b0, 13'h020, 32'h0, 4'h0); clken = 1'b0;
        #1 chk_b("stall_vld", a1.readdatavalid, 1'b0);
        chk_b("stall_wait", a1.waitrequest, 1'b1);
        repeat (2) begin
            @(negedge clk);
            #1 chk_b("stall_vld", a1.readdatavalid, 1'b0);
            chk_b("stall_wait", a1.waitrequest, 1'b1);
        end
        @(negedge clk) clken = 1'b1;
        #1 chk_b("b2b1_vld", a1.readdatavalid, 1'b1);
        chk("b2b1_dat", a1.readdata, 32'hAA22AA44);
        @(negedge clk) set_a1(1'b1, 1'b1, 1'b0, 13'h030, 32'h0, 4'h0);
        #1 chk_b("b2b2_vld", a1.readdatavalid, 1'b1);
        chk("b2b2_dat", a1.readdata, 32'h0000EEFF);
        @(negedge clk) idle();
        #1 chk_b("b2b3_vld", a1.readdatavalid, 1'b1);
        chk("b2b3_dat", a1.readdata, 32'h5);
        @(negedge clk);
        #1 chk_b("b2b_end", a1.readdatavalid, 1'b0);

        // Latency-2 instance.
        @(negedge clk) set_b2(1'b1, 1'b0, 1'b1, 13'h005, 32'hDEADBEEF, 4'hF);
        @(negedge clk) idle(); set_b1(1'b1, 1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        @(negedge clk) idle();
        #1 chk_b("lat2_p1", b1.readdatavalid, 1'b0);
        @(negedge clk);
        #1 chk_b("lat2_p2_vld", b1.readdatavalid, 1'b1);
        chk("lat2_p2_dat", b1.readdata, 32'hDEADBEEF);
        @(negedge clk);
        #1 chk_b("lat2_p3", b1.readdatavalid, 1'b0);

        // Reset with reads in flight.
        @(negedge clk) set_b1(1'b1, 1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        set_a1(1'b1, 1'b1, 1'b0, 13'h010, 32'h0, 4'h0);
        @(negedge clk) idle(); set_b1(1'b1, 1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        @(negedge clk) idle(); reset_n = 1'b0;
        #1 chk_b("mrst_b1_vld", b1.readdatavalid, 1'b0);
        chk("mrst_b1_dat", b1.readdata, 32'h0);
        chk_b("mrst_a1_vld", a1.readdatavalid, 1'b0);
        chk("mrst_a1_dat", a1.readdata, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        #1 chk_b("post_rst_b1_vld", b1.readdatavalid, 1'b0);
        chk_b("post_rst_a1_vld", a1.readdatavalid, 1'b0);
        @(negedge clk);
        #1 chk_b("post_rst_b1_vld2", b1.readdatavalid, 1'b0);
        @(negedge clk) set_a1(1'b1, 1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        @(negedge clk) idle();
        #1 chk_b("ram_kept_vld", a1.readdatavalid, 1'b1);
        chk("ram_kept_dat", a1.readdata, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
